// File: rtl/fifo_stream_reader.sv
// Read-side adapter: pops a synchronous FIFO and presents words on a registered valid/ready stream.
// Optional pop/stall counters are built when FIFO_STREAM_READER_STATS_EN is defined.
module fifo_stream_reader #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [31:0]      word_count,
  output logic [31:0]      stall_count
`endif
);

  logic [1:0]       r_occ;
  logic             r_inflight;
  logic             r_valid;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_skid;

  logic             w_pop;
  logic [2:0]       w_load;
  logic [1:0]       w_occ_nxt;
  logic [WIDTH-1:0] w_head_nxt;
  logic [WIDTH-1:0] w_skid_nxt;

  assign w_pop      = r_valid & m_ready;
  // Slots committed after this edge; a pop frees one in the same cycle.
  assign w_load     = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign fifo_rd_en = reset_n & enable & ~fifo_empty & (w_load < 3'd2);
  assign m_valid    = r_valid;
  assign m_data     = r_head;

  always_comb begin
    w_occ_nxt  = r_occ;
    w_head_nxt = r_head;
    w_skid_nxt = r_skid;
    if (r_inflight) begin
      if (r_occ == 2'd0 || (r_occ == 2'd1 && w_pop)) begin
        w_head_nxt = fifo_rd_data;
        w_occ_nxt  = 2'd1;
      end else if (r_occ == 2'd2 && w_pop) begin
        w_head_nxt = r_skid;
        w_skid_nxt = fifo_rd_data;
      end else begin
        w_skid_nxt = fifo_rd_data;
        w_occ_nxt  = 2'd2;
      end
    end else if (w_pop) begin
      if (r_occ == 2'd2) begin
        w_head_nxt = r_skid;
        w_occ_nxt  = 2'd1;
      end else begin
        w_occ_nxt  = 2'd0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
      r_head     <= '0;
    end else begin
      assert ({1'b0, r_occ} + {2'b0, r_inflight} <= 3'd2);
      r_occ      <= w_occ_nxt;
      r_inflight <= fifo_rd_en;
      r_valid    <= (w_occ_nxt != 2'd0);
      r_head     <= w_head_nxt;
      r_skid     <= w_skid_nxt;
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      word_count  <= '0;
      stall_count <= '0;
    end else begin
      if (w_pop)              word_count  <= word_count + 32'd1;
      if (r_valid & ~m_ready) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural one-cycle-latency FIFO.
module tb_fifo_stream_reader;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n, enable, m_ready;
  logic         fifo_empty, fifo_rd_en, m_valid;
  logic [W-1:0] fifo_rd_data, m_data;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0]  word_count, stall_count;
`endif

  logic [W-1:0] mem [0:63];
  int           rd_ptr = 0;
  int           wr_ptr = 0;
  int           cyc = 0;
  logic [W-1:0] rx [$];
  int           rx_cyc [$];
  int           checks = 0;
  int           errors = 0;
  int           base, rbase;

  always #5 clock = ~clock;

  fifo_stream_reader #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
`ifdef FIFO_STREAM_READER_STATS_EN
    , .word_count(word_count), .stall_count(stall_count)
`endif
  );

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr[5:0]];
      rd_ptr       <= rd_ptr + 1;
    end
    if (reset_n && m_valid && m_ready) begin
      rx.push_back(m_data);
      rx_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [W-1:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rxw(input int idx);
    if (rx.size() > idx) return rx[idx];
    return 'x;
  endfunction

  task automatic wait_rx(input int n, input string tag);
    int k = 0;
    while (rx.size() < n && k < 64) begin
      tick;
      k++;
    end
    chk(tag, 32'(rx.size() >= n), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; m_ready = 1'b0;
    push(32'hA5A5_0001);

    // Reset holds everything quiet even with a non-empty FIFO
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
    end

    // Single word: rd_en in cycle 0, visible in cycle 2 only
    reset_n = 1'b1; m_ready = 1'b1;
    #1 chk("single_rd_en0", fifo_rd_en, 1);
    tick;
    chk("single_rd_en_empty", fifo_rd_en, 0);
    chk("single_valid1", m_valid, 0);
    tick;
    chk("single_valid2", m_valid, 1);
    chk("single_data2", m_data, 32'hA5A5_0001);
    tick;
    chk("single_valid3", m_valid, 0);

    // Streaming 1..16 with no bubbles
    base = rx.size();
    for (int i = 1; i <= 16; i++) push(32'(i));
    wait_rx(base + 16, "stream_timeout");
    for (int i = 0; i < 16; i++) chk($sformatf("stream_w%0d", i + 1), rxw(base + i), 32'(i + 1));
    if (rx_cyc.size() >= base + 16)
      chk("stream_span", 32'(rx_cyc[base + 15] - rx_cyc[base]), 32'd15);
    else
      chk("stream_span", 32'hFFFF_FFFF, 32'd15);
    tick; tick;

    // Backpressure: stall 5 cycles once word 1 appears
    base = rx.size(); rbase = rd_ptr;
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(32'(i));
    #1 chk("bp_rd_en0", fifo_rd_en, 1);
    tick; tick;
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("bp_hold_data", m_data, 32'd1);
      chk("bp_hold_valid", m_valid, 1);
      chk("bp_rd_en_off", fifo_rd_en, 0);
    end
    chk("bp_fetched", 32'(rd_ptr - rbase), 32'd2);
    m_ready = 1'b1;
    wait_rx(base + 8, "bp_timeout");
    for (int i = 0; i < 8; i++) chk($sformatf("bp_w%0d", i + 1), rxw(base + i), 32'(i + 1));
    tick; tick; tick;
    chk("bp_no_dup", 32'(rx.size() - base), 32'd8);
    chk("bp_drained", m_valid, 0);

    // Enable gating: the inflight word still arrives
    base = rx.size();
    push(32'h77); push(32'h78);
    #1 chk("en_rd_en0", fifo_rd_en, 1);
    tick;
    enable = 1'b0;
    #1 chk("en_rd_en_off", fifo_rd_en, 0);
    tick;
    chk("en_valid", m_valid, 1);
    chk("en_data", m_data, 32'h77);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("en_no_pop", fifo_rd_en, 0);
    end
    chk("en_one_word", 32'(rx.size() - base), 32'd1);
    chk("en_w0", rxw(base), 32'h77);
    enable = 1'b1;
    #1 chk("en_resume", fifo_rd_en, 1);
    wait_rx(base + 2, "en_timeout");
    chk("en_w1", rxw(base + 1), 32'h78);
    tick; tick;

    // Mid-stream reset with a buffered head and an inflight word
    m_ready = 1'b0;
    push(32'h41); push(32'h42); push(32'h43); push(32'h44);
    tick; tick;
    chk("mr_valid_pre", m_valid, 1);
    chk("mr_data_pre", m_data, 32'h41);
    reset_n = 1'b0;
    tick;
    chk("mr_valid", m_valid, 0);
    chk("mr_data", m_data, 0);
    chk("mr_rd_en", fifo_rd_en, 0);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("mr_word_count", word_count, 0);
`endif
    tick;
    base = rx.size();
    reset_n = 1'b1; m_ready = 1'b1;
    #1 chk("mr_rd_en_resume", fifo_rd_en, 1);
    chk("mr_valid_after", m_valid, 0);
    wait_rx(base + 2, "mr_timeout");
    chk("mr_w0", rxw(base), 32'h43);
    chk("mr_w1", rxw(base + 1), 32'h44);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("stats_words", word_count, 32'd2);
    chk("stats_stalls", stall_count, 32'd0);
`endif
    tick; tick;
    chk("mr_drained", m_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
